// File: rtl/rot_sched_pkg.sv
// Shared widths, FSM state type and the left-to-right rotate amount conversion.
package rot_sched_pkg;

  localparam int DATA_W = 8;
  localparam int AMT_W  = 3;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  // A left rotate by n is a right rotate by (DATA_W - n) mod DATA_W.
  function automatic logic [AMT_W-1:0] left_to_right(input logic [AMT_W-1:0] amt);
    logic [AMT_W:0] diff;
    diff = (AMT_W+1)'(DATA_W) - {1'b0, amt};
    return diff[AMT_W-1:0];
  endfunction

endpackage

// File: rtl/rot_sched_rot8_core.sv
// Purely combinational 8-bit right rotator: result[k] = data[(k+amt) mod 8].
module rot8_core
  import rot_sched_pkg::*;
(
  input  logic [DATA_W-1:0] data,
  input  logic [AMT_W-1:0]  amt,
  output logic [DATA_W-1:0] result
);

  logic [2*DATA_W-1:0] doubled;

  assign doubled = {data, data} >> amt;
  assign result  = doubled[DATA_W-1:0];

endmodule

// File: rtl/rot_sched.sv
// Round-robin requesters share one rotator; result registered with 1-cycle latency and held while out_ready=0.
// Accepts while draining for full throughput. Macro ROT_LEFT_EN adds req_left and left rotates.
module rot_sched
  import rot_sched_pkg::*;
#(
  parameter  int NREQ = 2,
  localparam int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*DATA_W-1:0]   req_data,
  input  logic [NREQ*AMT_W-1:0]    req_amt,
`ifdef ROT_LEFT_EN
  input  logic [NREQ-1:0]          req_left,
`endif
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [ID_W-1:0]          out_id,
  output logic [15:0]              done_cnt
);

  state_t            state, state_nxt;
  logic [ID_W-1:0]   last_grant;
  logic [ID_W-1:0]   grant;
  logic [ID_W-1:0]   cand;
  logic              found;
  logic              can_accept;
  logic              accept;

  logic [DATA_W-1:0] data_arr [NREQ];
  logic [AMT_W-1:0]  amt_arr  [NREQ];
  logic [DATA_W-1:0] sel_data;
  logic [AMT_W-1:0]  sel_amt;
  logic [AMT_W-1:0]  eff_amt;
  logic [DATA_W-1:0] rot_result;

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign data_arr[i] = req_data[i*DATA_W +: DATA_W];
    assign amt_arr[i]  = req_amt[i*AMT_W +: AMT_W];
  end

  always_comb begin
    found = 1'b0;
    grant = '0;
    cand  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = ID_W'((int'(last_grant) + k) % NREQ);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        grant = cand;
      end
    end
  end

  // rst_n gates acceptance so req_ready reads 0 throughout reset.
  assign can_accept = rst_n && ((state == EMPTY) || out_ready);
  assign accept     = can_accept && found;

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[grant] = 1'b1;
  end

  assign sel_data = data_arr[grant];
  assign sel_amt  = amt_arr[grant];

`ifdef ROT_LEFT_EN
  assign eff_amt = req_left[grant] ? left_to_right(sel_amt) : sel_amt;
`else
  assign eff_amt = sel_amt;
`endif

  rot8_core u_core (
    .data   (sel_data),
    .amt    (eff_amt),
    .result (rot_result)
  );

  always_comb begin
    state_nxt = state;
    out_valid = 1'b0;
    case (state)
      EMPTY: begin
        if (accept) state_nxt = FULL;
      end
      FULL: begin
        out_valid = 1'b1;
        if (out_ready && !accept) state_nxt = EMPTY;
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data   <= '0;
      out_id     <= '0;
      last_grant <= ID_W'(NREQ - 1);
    end else if (accept) begin
      out_data   <= rot_result;
      out_id     <= grant;
      last_grant <= grant;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_cnt <= '0;
    end else if (out_valid && out_ready && (done_cnt != 16'hFFFF)) begin
      done_cnt <= done_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_rot_sched.sv
// Self-checking bench for rot_sched against a transaction-level reference model.
module tb_rot_sched;

  localparam int NREQ = 2;
  localparam int ID_W = 1;

  logic                 clk;
  logic                 rst_n;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*8-1:0]    req_data;
  logic [NREQ*3-1:0]    req_amt;
`ifdef ROT_LEFT_EN
  logic [NREQ-1:0]      req_left;
`endif
  logic                 out_valid;
  logic                 out_ready;
  logic [7:0]           out_data;
  logic [ID_W-1:0]      out_id;
  logic [15:0]          done_cnt;

  int vectors;
  int miscompares;

  // Reference model state
  bit       m_full;
  logic [7:0] m_data;
  int       m_id;
  int       m_cnt;
  int       m_last;

  rot_sched #(.NREQ(NREQ)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .req_amt   (req_amt),
`ifdef ROT_LEFT_EN
    .req_left  (req_left),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_id    (out_id),
    .done_cnt  (done_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] rot_right(input logic [7:0] d, input int amt);
    logic [7:0] r;
    logic [2:0] src;
    logic [2:0] dst;
    r = '0;
    for (int k = 0; k < 8; k++) begin
      dst = 3'(k);
      src = 3'((k + amt) % 8);
      r[dst] = d[src];
    end
    return r;
  endfunction

  function automatic int pick(input logic [NREQ-1:0] v);
    logic [NREQ-1:0] t;
    for (int k = 1; k <= NREQ; k++) begin
      t = v >> ((m_last + k) % NREQ);
      if (t[0]) return (m_last + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] exp_ready(input logic [NREQ-1:0] v, input logic ordy);
    int w;
    w = pick(v);
    if ((!m_full || ordy) && w >= 0) return NREQ'(1) << w;
    return '0;
  endfunction

  task automatic model_reset();
    m_full = 0; m_data = 8'h00; m_id = 0; m_cnt = 0; m_last = NREQ - 1;
  endtask

  task automatic drive(input logic [NREQ-1:0] v, input logic [15:0] d, input logic [5:0] a,
                       input logic [NREQ-1:0] l, input logic ordy);
    req_valid = v;
    req_data  = d;
    req_amt   = a;
`ifdef ROT_LEFT_EN
    req_left  = l;
`else
    if (l != 0) $display("note: left flag ignored in right-only build");
`endif
    out_ready = ordy;
    #1;
  endtask

  // Advance one clock and update the model from the inputs currently driven.
  task automatic tick();
    int w;
    int amt;
    logic [NREQ*8-1:0] dt;
    logic [NREQ*3-1:0] at;
`ifdef ROT_LEFT_EN
    logic [NREQ-1:0] lt;
`endif
    w = pick(req_valid);
    if (m_full && out_ready && m_cnt < 65535) m_cnt++;
    if (w >= 0 && (!m_full || out_ready)) begin
      dt = req_data >> (8 * w);
      at = req_amt >> (3 * w);
      amt = int'(at[2:0]);
`ifdef ROT_LEFT_EN
      lt = req_left >> w;
      if (lt[0]) amt = (8 - amt) % 8;
`endif
      m_full = 1; m_id = w; m_last = w;
      m_data = rot_right(dt[7:0], amt);
    end else if (m_full && out_ready) begin
      m_full = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(2'b11, 16'hA5C3, 6'o12, 2'b00, 1'b1);
    #2;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
    vectors++; if (out_data !== 8'h00) begin miscompares++; $display("FAIL reset_out_data got=%h exp=00", out_data); end
    vectors++; if (out_id !== '0) begin miscompares++; $display("FAIL reset_out_id got=%0d exp=0", out_id); end
    vectors++; if (done_cnt !== 16'h0) begin miscompares++; $display("FAIL reset_done_cnt got=%h exp=0000", done_cnt); end
    vectors++; if (req_ready !== 2'b00) begin miscompares++; $display("FAIL reset_req_ready got=%b exp=00", req_ready); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    drive(2'b00, 16'h0, 6'o0, 2'b00, 1'b1);
  endtask

  task automatic test_right_rotate();
    drive(2'b01, 16'h00B4, 6'o01, 2'b00, 1'b1);
    vectors++; if (req_ready !== 2'b01) begin miscompares++; $display("FAIL rr_first_grant got=%b exp=01", req_ready); end
    tick();
    drive(2'b00, 16'h0, 6'o0, 2'b00, 1'b1);
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL rot_valid got=%0b exp=1", out_valid); end
    vectors++; if (out_data !== 8'h5A) begin miscompares++; $display("FAIL rot_data got=%h exp=5a", out_data); end
    vectors++; if (out_id !== 1'b0) begin miscompares++; $display("FAIL rot_id got=%0d exp=0", out_id); end
    tick();
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rot_drain got=%0b exp=0", out_valid); end
    vectors++; if (done_cnt !== 16'd1) begin miscompares++; $display("FAIL rot_done_cnt got=%0d exp=1", done_cnt); end
  endtask

  task automatic test_round_robin();
    rst_n = 1'b0; #1; rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 6; i++) begin
      drive(2'b11, 16'($urandom), 6'($urandom), 2'b00, 1'b1);
      vectors++;
      if (req_ready !== (2'b01 << (i % 2))) begin
        miscompares++; $display("FAIL rr_grant[%0d] got=%b exp=%b", i, req_ready, 2'b01 << (i % 2));
      end
      tick();
      vectors++;
      if (out_valid !== 1'b1 || out_id !== 1'(i % 2) || out_data !== m_data) begin
        miscompares++;
        $display("FAIL rr_result[%0d] got=v%0b id%0d d%h exp=v1 id%0d d%h", i, out_valid, out_id, out_data, i % 2, m_data);
      end
    end
    drive(2'b00, 16'h0, 6'o0, 2'b00, 1'b1);
    tick();
  endtask

  task automatic test_backpressure();
    logic [15:0] saved;
    drive(2'b01, 16'h0012, 6'o04, 2'b00, 1'b0);
    tick();
    saved = done_cnt;
    for (int i = 0; i < 3; i++) begin
      drive(2'b11, 16'($urandom), 6'($urandom), 2'b00, 1'b0);
      vectors++; if (req_ready !== 2'b00) begin miscompares++; $display("FAIL bp_ready[%0d] got=%b exp=00", i, req_ready); end
      vectors++; if (out_data !== 8'h21 || out_valid !== 1'b1) begin miscompares++; $display("FAIL bp_hold[%0d] got=%h v%0b exp=21 v1", i, out_data, out_valid); end
      vectors++; if (done_cnt !== saved) begin miscompares++; $display("FAIL bp_cnt[%0d] got=%0d exp=%0d", i, done_cnt, saved); end
      tick();
    end
    drive(2'b00, 16'h0, 6'o0, 2'b00, 1'b1);
    tick();
    vectors++; if (done_cnt !== saved + 16'd1) begin miscompares++; $display("FAIL bp_release_cnt got=%0d exp=%0d", done_cnt, saved + 16'd1); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL bp_release_valid got=%0b exp=0", out_valid); end
  endtask

`ifdef ROT_LEFT_EN
  task automatic test_left_rotate();
    drive(2'b01, 16'h0081, 6'o01, 2'b01, 1'b1);
    tick();
    vectors++; if (out_data !== 8'h03) begin miscompares++; $display("FAIL left_rot got=%h exp=03", out_data); end
    drive(2'b10, 16'h6700, 6'o00, 2'b10, 1'b1);
    tick();
    vectors++; if (out_data !== 8'h67) begin miscompares++; $display("FAIL left_amt0 got=%h exp=67", out_data); end
    drive(2'b00, 16'h0, 6'o0, 2'b00, 1'b1);
    tick();
  endtask
`endif

  task automatic test_random();
    logic [NREQ-1:0] er;
    for (int i = 0; i < 400; i++) begin
      drive(2'($urandom), 16'($urandom), 6'($urandom), 2'($urandom), 1'($urandom_range(0, 3) != 0));
      er = exp_ready(req_valid, out_ready);
      vectors++; if (req_ready !== er) begin miscompares++; $display("FAIL rand_ready[%0d] got=%b exp=%b", i, req_ready, er); end
      tick();
      vectors++;
      if (out_valid !== 1'(m_full) || (m_full && (out_data !== m_data || out_id !== 1'(m_id))) ||
          done_cnt !== 16'(m_cnt)) begin
        miscompares++;
        $display("FAIL rand_out[%0d] got=v%0b d%h id%0d c%0d exp=v%0b d%h id%0d c%0d",
                 i, out_valid, out_data, out_id, done_cnt, m_full, m_data, m_id, m_cnt);
      end
    end
  endtask

  task automatic test_reset_mid();
    drive(2'b10, 16'h3C00, 6'o20, 2'b00, 1'b0);
    tick();
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL mid_full got=%0b exp=1", out_valid); end
    drive(2'b11, 16'h1111, 6'o11, 2'b00, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL mid_async_valid got=%0b exp=0", out_valid); end
    vectors++; if (done_cnt !== 16'h0) begin miscompares++; $display("FAIL mid_async_cnt got=%0d exp=0", done_cnt); end
    vectors++; if (req_ready !== 2'b00) begin miscompares++; $display("FAIL mid_ready_in_reset got=%b exp=00", req_ready); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    drive(2'b11, 16'h8040, 6'o00, 2'b00, 1'b1);
    vectors++; if (req_ready !== 2'b01) begin miscompares++; $display("FAIL mid_first_grant got=%b exp=01", req_ready); end
    tick();
    vectors++; if (out_id !== 1'b0 || out_data !== 8'h40) begin miscompares++; $display("FAIL mid_first_result got=id%0d d%h exp=id0 d40", out_id, out_data); end
    drive(2'b00, 16'h0, 6'o0, 2'b00, 1'b1);
    tick();
  endtask

  task automatic test_saturation();
    rst_n = 1'b0; #1; rst_n = 1'b1;
    model_reset();
    drive(2'b01, 16'h00FF, 6'o00, 2'b00, 1'b1);
    for (int i = 0; i < 65540; i++) tick();
    vectors++; if (done_cnt !== 16'hFFFF) begin miscompares++; $display("FAIL sat_cnt got=%h exp=ffff", done_cnt); end
    vectors++; if (done_cnt !== 16'(m_cnt)) begin miscompares++; $display("FAIL sat_model got=%h exp=%h", done_cnt, 16'(m_cnt)); end
    tick();
    vectors++; if (done_cnt !== 16'hFFFF || out_valid !== 1'b1) begin miscompares++; $display("FAIL sat_hold got=%h v%0b exp=ffff v1", done_cnt, out_valid); end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    model_reset();
    test_reset();
    test_right_rotate();
    test_round_robin();
    test_backpressure();
`ifdef ROT_LEFT_EN
    test_left_rotate();
`endif
    test_random();
    test_reset_mid();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rot_sched.md
ROT_SCHED -- requirements
Module: rot_sched

Interface
- REQ-001: Parameter NREQ, default 2, is the number of requesters, legal range 2..8.
- REQ-002: clk, input, 1: the single clock; all state updates on its rising edge.
- REQ-003: rst_n, input, 1: reset, asynchronous assert, active-low.
- REQ-004: req_valid, input, NREQ: per-requester request valid.
- REQ-005: req_ready, output, NREQ: per-requester accept; a transfer occurs when valid and ready are both 1 in a cycle.
- REQ-006: req_data, input, NREQ*8: operand; slice i is bits [8i+7:8i].
- REQ-007: req_amt, input, NREQ*3: rotate amount; slice i is bits [3i+2:3i].
- REQ-008: req_left, input, NREQ: direction, 1 means rotate left; present only under ROT_LEFT_EN.
- REQ-009: out_valid, output, 1: result valid.
- REQ-010: out_ready, input, 1: consumer accept.
- REQ-011: out_data, output, 8: rotated result.
- REQ-012: out_id, output, max(1,$clog2(NREQ)): index of the requester that owns out_data.
- REQ-013: done_cnt, output, 16: count of results delivered, saturating.

Function
- REQ-014: The FSM SHALL have two states, EMPTY (no result held) and FULL (result held, out_valid=1).
- REQ-015: The block can accept a request when the state is EMPTY, or when it is FULL and out_ready=1 in the same cycle, giving full throughput.
- REQ-016: When it can accept and any req_valid is 1, the block SHALL assert exactly one req_ready bit, the round-robin winner; otherwise all req_ready bits are 0.
- REQ-017: Round-robin search starts at index (last_grant+1) mod NREQ and ascends with wrap-around; last_grant updates only on an accepted transfer.
- REQ-018: req_ready SHALL be combinational from req_valid, state, out_ready and last_grant; it does not depend on req_data or req_amt.
- REQ-019: Right rotate means out_data[k] = data[(k+amt) mod 8]; amt=0 passes the data through unchanged.
- REQ-020: Left rotate (ROT_LEFT_EN only) uses an effective right amount of (8-amt) mod 8.
- REQ-021: Latency is 1 cycle: the result registered on the accept edge is visible on out_data/out_id in the next cycle with out_valid=1.
- REQ-022: State transitions:
  - EMPTY to FULL on accept.
  - FULL to EMPTY on out_ready with no accept.
  - FULL stays FULL on out_ready with accept, with the new result loaded.
  - FULL stays FULL without out_ready, and out_data/out_id are held stable.
- REQ-023: done_cnt increments on each out_valid&&out_ready cycle and saturates at 16'hFFFF.
- REQ-024: A requester that drops req_valid before being granted loses nothing; a grant is never issued without the matching valid.

Reset
- REQ-025: On rst_n=0, immediately and regardless of clk:
  - state becomes EMPTY;
  - out_valid=0, out_data=8'h00, out_id=0, done_cnt=0;
  - last_grant=NREQ-1, so requester 0 wins first;
  - req_ready=0.
- REQ-026: Reset mid-operation discards any held result with no output transfer; the first accept after deassertion follows REQ-025 priority.

Configuration
- REQ-027: Macro ROT_LEFT_EN. When defined, the req_left port exists and REQ-020 applies. When undefined, the port is absent and all rotates are right rotates.

Structure
- REQ-028: Package rot_sched_pkg SHALL hold DATA_W=8, AMT_W=3, the state enum (EMPTY, FULL), and a function for the left-to-right amount conversion.
- REQ-029: Sub-module rot8_core SHALL be a purely combinational 8-bit right rotator (data, 3-bit amount, result), instantiated once and shared by all requesters through the grant mux.

Verification
- REQ-030: Right-rotate check: req0 sends data 8'hB4, amt 1, with out_ready=1 -> next cycle out_valid=1, out_data=8'h5A, out_id=0.
- REQ-031: Round-robin check: req0 and req1 valid continuously with out_ready=1 -> grants alternate 0,1,0,1 from reset, one result per cycle.
- REQ-032: Backpressure check: send data 8'h12, amt 4, and hold out_ready=0 for 3 cycles -> out_data=8'h21 stable, req_ready all 0, done_cnt unchanged; then out_ready=1 -> done_cnt increments by 1.
- REQ-033: Left-rotate check (ROT_LEFT_EN): send data 8'h81, amt 1, left=1 -> 8'h03. Also send amt 0 with left=1 -> data unchanged.
- REQ-034: Reset check: assert rst_n=0 while FULL -> out_valid drops without a clock edge. After release, with both requesters valid, req0 is granted first.
- REQ-035: Saturation check: force 65536 deliveries -> done_cnt stays at 16'hFFFF.
